// File: rtl/axi_write_coalescer_if.sv
// AXI4 write channels (AW, W, B) between the coalescer (master) and the DDR-side slave.
// A beat transfers on a rising clk edge where valid and ready are both high; a source holds valid and its payload stable until then.
interface axi_write_coalescer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_write_coalescer.sv
// Packs address-contiguous single-word GPU writes into AXI4 INCR bursts, one outstanding
// transaction at a time. o_state exposes the FSM (0 FILL, 1 AW, 2 W, 3 B).
module axi_write_coalescer #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int MAX_BURST     = 16,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    input  logic                    i_flush,
    output logic                    o_idle,
    output logic                    o_err,
    input  logic                    i_err_clr,
    output logic [1:0]              o_state,
    axi_write_coalescer_if.master   m_axi
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam int BW = $clog2(MAX_BURST);
    localparam int TW = $clog2(FLUSH_TIMEOUT) + 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_FILL, S_AW, S_W, S_B} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         beat;
    logic [TW-1:0]         idle_ctr;
    logic                  err;
    logic [DATA_WIDTH-1:0] data_buf [MAX_BURST];
    logic [SW-1:0]         strb_buf [MAX_BURST];

    logic [ADDR_WIDTH-1:0] addr_al;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  contig;
    logic                  accept;
    logic                  full, boundary, hold, do_flush, timeout;
    logic                  last_beat;

    assign addr_al   = i_req_addr & ~ADDR_WIDTH'(3);
    assign next_addr = base + (ADDR_WIDTH'(cnt) << 2);
    assign contig    = (cnt == '0) || (addr_al == next_addr);
    assign last_beat = ({1'b0, beat} == (cnt - CW'(1)));

    always_comb begin
        state_n     = state;
        o_req_ready = 1'b0;
        accept      = 1'b0;
        full        = 1'b0;
        boundary    = 1'b0;
        hold        = 1'b0;
        do_flush    = 1'b0;
        timeout     = 1'b0;
        case (state)
            S_FILL: begin
                o_req_ready = !i_flush && contig;
                accept      = i_req_valid && o_req_ready;
                full        = accept && (cnt == CW'(MAX_BURST - 1));
                // The word just taken ends a 4 KB page; AXI bursts may not cross it.
                boundary    = accept && (addr_al[11:0] == 12'hFFC);
                hold        = i_req_valid && !contig;
                do_flush    = i_flush && (cnt != '0);
                timeout     = (cnt != '0) && (idle_ctr == TW'(FLUSH_TIMEOUT - 1));
                if (full || boundary || hold || do_flush || timeout) state_n = S_AW;
            end
            S_AW:    if (m_axi.awready) state_n = S_W;
            S_W:     if (m_axi.wready && last_beat) state_n = S_B;
            S_B:     if (m_axi.bvalid) state_n = S_FILL;
            default: state_n = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FILL;
            base     <= '0;
            cnt      <= '0;
            beat     <= '0;
            idle_ctr <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt <= cnt + CW'(1);
                if (cnt == '0) base <= addr_al;
            end
            if (accept || cnt == '0) idle_ctr <= '0;
            else if (state == S_FILL) idle_ctr <= idle_ctr + TW'(1);
            if (state == S_AW && m_axi.awready) beat <= '0;
            if (state == S_W && m_axi.wready) beat <= beat + BW'(1);
            if (state == S_B && m_axi.bvalid) begin
                cnt      <= '0;
                idle_ctr <= '0;
            end
            // An error arriving in the same cycle as a clear must not be lost.
            if (state == S_B && m_axi.bvalid && m_axi.bresp != 2'b00) err <= 1'b1;
            else if (i_err_clr) err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_buf[cnt[BW-1:0]] <= i_req_wdata;
            strb_buf[cnt[BW-1:0]] <= i_req_wstrb;
        end
    end

    assign m_axi.awid    = ID_WIDTH'(0);
    assign m_axi.awvalid = (state == S_AW);
    assign m_axi.awaddr  = (state == S_AW) ? base : '0;
    assign m_axi.awlen   = (state == S_AW) ? 8'(cnt - CW'(1)) : 8'd0;
    assign m_axi.awsize  = (state == S_AW) ? 3'b010 : 3'b000;
    assign m_axi.awburst = (state == S_AW) ? 2'b01 : 2'b00;
    assign m_axi.awcache = (state == S_AW) ? 4'b0011 : 4'b0000;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;

    assign m_axi.wvalid  = (state == S_W);
    assign m_axi.wdata   = (state == S_W) ? data_buf[beat] : '0;
    assign m_axi.wstrb   = (state == S_W) ? strb_buf[beat] : '0;
    assign m_axi.wlast   = (state == S_W) && last_beat;
    assign m_axi.bready  = (state == S_B);

    assign o_idle  = (state == S_FILL) && (cnt == '0);
    assign o_err   = err;
    assign o_state = state;
endmodule

// File: tb/tb_axi_write_coalescer.sv
// Bench for axi_write_coalescer: directed writes, AXI slave model, and a monitor that pops
// hand-computed AW/W expectations from queues on every handshake.
module tb_axi_write_coalescer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MB = 16;
    localparam int FT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic          flush = 1'b0;
    logic          idle;
    logic          err;
    logic          err_clr = 1'b0;
    logic [1:0]    state;

    always #5 clk = ~clk;

    axi_write_coalescer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    axi_write_coalescer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_BURST(MB), .FLUSH_TIMEOUT(FT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .i_flush(flush), .o_idle(idle), .o_err(err), .i_err_clr(err_clr),
        .o_state(state), .m_axi(axi)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [39:0] exp_aw_q[$];
    logic [36:0] exp_w_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // slave model
    int          aw_delay = 0;
    int          aw_wait  = 0;
    bit          w_toggle = 0;
    bit          w_stall  = 0;
    logic [1:0]  next_bresp = 2'b00;
    bit          b_hs_next = 0;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                aw_wait     = 0;
            end else begin
                if (axi.awvalid) begin
                    axi.awready = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    axi.awready = 1'b0;
                    aw_wait     = 0;
                end
                if (w_stall) axi.wready = 1'b0;
                else if (w_toggle) axi.wready = ~axi.wready;
                else axi.wready = 1'b1;
                if (b_hs_next) axi.bvalid = 1'b0;
                else if (axi.bready && !axi.bvalid) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = next_bresp;
                end
            end
        end
    end

    // monitor / scoreboard
    bit          aw_pend = 0;
    bit          w_pend  = 0;
    bit          aw_prev = 0;
    logic [39:0] aw_snap;
    logic [36:0] w_snap;
    int          aw_rise = -1;
    int          aw_hs   = -1;
    int          b_hs    = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_pend = 0; w_pend = 0; aw_prev = 0; b_hs_next = 0;
            end else begin
                if (axi.awvalid && !aw_prev) aw_rise = cyc;
                aw_prev = axi.awvalid;
                if (axi.awvalid) begin
                    if (aw_pend) check("aw_stable", {axi.awaddr, axi.awlen}, aw_snap);
                    if (axi.awready) begin
                        aw_hs = cyc;
                        if (exp_aw_q.size() == 0) check("aw_unexpected", {axi.awaddr, axi.awlen}, 64'hFFFF_FFFF_FFFF_FFFF);
                        else check("aw", {axi.awaddr, axi.awlen}, exp_aw_q.pop_front());
                        check("aw_attr", {axi.awsize, axi.awburst, axi.awcache, axi.awlock, axi.awprot, axi.awqos, axi.awid},
                              {3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000, 4'b0000});
                        aw_pend = 0;
                    end else begin
                        aw_pend = 1;
                        aw_snap = {axi.awaddr, axi.awlen};
                    end
                end
                if (axi.wvalid) begin
                    if (w_pend) check("w_stable", {axi.wlast, axi.wstrb, axi.wdata}, w_snap);
                    if (axi.wready) begin
                        if (exp_w_q.size() == 0) check("w_unexpected", {axi.wlast, axi.wstrb, axi.wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                        else check("w", {axi.wlast, axi.wstrb, axi.wdata}, exp_w_q.pop_front());
                        w_pend = 0;
                    end else begin
                        w_pend = 1;
                        w_snap = {axi.wlast, axi.wstrb, axi.wdata};
                    end
                end
                b_hs_next = axi.bvalid && axi.bready;
                if (b_hs_next) b_hs = cyc;
                if (axi.awvalid || axi.wvalid || axi.bready) check("ready_low_in_burst", req_ready, 0);
            end
        end
    end

    // drivers
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int acc, output logic rdy0);
        bit ok;
        ok = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
        #1;
        rdy0 = req_ready;
        for (int t = 0; t < 300; t++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            check("send_timeout", 0, 1);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc - 1;
        end
    endtask

    task automatic idle_req();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (idle) begin ok = 1; break; end
        end
        check("wait_idle", ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int   acc;
        int   acc1;
        logic r0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}, 0);
        check("rst_idle", idle, 1);
        check("rst_ready", req_ready, 1);
        check("rst_err", err, 0);
        check("rst_aw_payload", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awcache}, 0);
        check("rst_w_payload", {axi.wdata, axi.wstrb}, 0);
        check("rst_state", state, 0);

        // flush with an empty buffer blocks ready but starts nothing
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("empty_flush_no_aw", {axi.awvalid, idle}, 2'b01);

        // full 16-beat burst
        exp_aw_q.push_back({32'h0000_1000, 8'd15});
        for (int i = 0; i < 16; i++) exp_w_q.push_back({(i == 15), 4'hF, 32'(i)});
        for (int i = 0; i < 16; i++) send(32'h1000 + 32'(4 * i), 32'(i), 4'hF, acc, r0);
        idle_req();
        wait_idle(200);
        check("full_aw_latency", aw_rise - acc, 1);
        check("full_aw_hs_same_cycle", aw_hs - aw_rise, 0);

        // timeout flush of a 3-word partial buffer
        exp_aw_q.push_back({32'h0000_2000, 8'd2});
        exp_w_q.push_back({1'b0, 4'hF, 32'h2000_0000});
        exp_w_q.push_back({1'b0, 4'h3, 32'h2000_0001});
        exp_w_q.push_back({1'b1, 4'hC, 32'h2000_0002});
        send(32'h2000, 32'h2000_0000, 4'hF, acc, r0);
        send(32'h2004, 32'h2000_0001, 4'h3, acc, r0);
        send(32'h2008, 32'h2000_0002, 4'hC, acc, r0);
        idle_req();
        wait_idle(300);
        check("timeout_latency", aw_rise - acc, FT + 1);

        // discontinuity holds the new address until B
        exp_aw_q.push_back({32'h0000_3000, 8'd1});
        exp_w_q.push_back({1'b0, 4'hF, 32'hA000_0000});
        exp_w_q.push_back({1'b1, 4'hF, 32'hA000_0001});
        exp_aw_q.push_back({32'h0000_5000, 8'd0});
        exp_w_q.push_back({1'b1, 4'h1, 32'hB000_0000});
        send(32'h3000, 32'hA000_0000, 4'hF, acc, r0);
        send(32'h3004, 32'hA000_0001, 4'hF, acc, r0);
        send(32'h5000, 32'hB000_0000, 4'h1, acc, r0);
        check("disc_held_ready", r0, 0);
        check("disc_accept_after_b", acc - b_hs, 1);
        flush_pulse();
        wait_idle(200);

        // 4 KB boundary splits the run
        exp_aw_q.push_back({32'h0000_0FF8, 8'd1});
        exp_w_q.push_back({1'b0, 4'hF, 32'hC000_0000});
        exp_w_q.push_back({1'b1, 4'hF, 32'hC000_0001});
        exp_aw_q.push_back({32'h0000_1000, 8'd0});
        exp_w_q.push_back({1'b1, 4'hF, 32'hC000_0002});
        send(32'h0FF8, 32'hC000_0000, 4'hF, acc, r0);
        send(32'h0FFC, 32'hC000_0001, 4'hF, acc1, r0);
        send(32'h1000, 32'hC000_0002, 4'hF, acc, r0);
        check("bound_aw_latency", aw_rise - acc1, 1);
        flush_pulse();
        wait_idle(200);

        // backpressure on AW and W; a contiguous request waits out the burst
        aw_delay = 5;
        w_toggle = 1;
        exp_aw_q.push_back({32'h0000_4000, 8'd3});
        exp_w_q.push_back({1'b0, 4'hF, 32'hD000_0000});
        exp_w_q.push_back({1'b0, 4'hE, 32'hD000_0001});
        exp_w_q.push_back({1'b0, 4'h7, 32'hD000_0002});
        exp_w_q.push_back({1'b1, 4'h8, 32'hD000_0003});
        exp_aw_q.push_back({32'h0000_4010, 8'd0});
        exp_w_q.push_back({1'b1, 4'hF, 32'hD000_0004});
        send(32'h4000, 32'hD000_0000, 4'hF, acc, r0);
        send(32'h4004, 32'hD000_0001, 4'hE, acc, r0);
        send(32'h4008, 32'hD000_0002, 4'h7, acc, r0);
        send(32'h400C, 32'hD000_0003, 4'h8, acc, r0);
        flush_pulse();
        send(32'h4010, 32'hD000_0004, 4'hF, acc, r0);
        check("bp_held_ready", r0, 0);
        check("bp_aw_wait", aw_hs - aw_rise, 5);
        flush_pulse();
        wait_idle(300);
        aw_delay = 0;
        w_toggle = 0;

        // error response, sticky flag, clear, set-beats-clear
        next_bresp = 2'b10;
        exp_aw_q.push_back({32'h0000_6000, 8'd0});
        exp_w_q.push_back({1'b1, 4'hF, 32'hE000_0000});
        send(32'h6000, 32'hE000_0000, 4'hF, acc, r0);
        flush_pulse();
        wait_idle(200);
        check("err_set", err, 1);
        next_bresp = 2'b00;
        @(negedge clk);
        #1;
        check("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_cleared", err, 0);
        next_bresp = 2'b11;
        exp_aw_q.push_back({32'h0000_6100, 8'd0});
        exp_w_q.push_back({1'b1, 4'hF, 32'hE000_0001});
        send(32'h6100, 32'hE000_0001, 4'hF, acc, r0);
        err_clr = 1'b1;
        flush_pulse();
        wait_idle(200);
        err_clr = 1'b0;
        check("err_set_beats_clr", err, 1);
        next_bresp = 2'b00;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // reset in the middle of the W phase
        w_stall = 1;
        exp_aw_q.push_back({32'h0000_7000, 8'd1});
        send(32'h7000, 32'hF000_0000, 4'hF, acc, r0);
        send(32'h7004, 32'hF000_0001, 4'hF, acc, r0);
        flush_pulse();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (axi.wvalid) break;
        end
        check("rst_reached_w", state, 2);
        rst = 1'b1;
        #1;
        check("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}, 0);
        check("rst_mid_idle", idle, 1);
        check("rst_mid_state", state, 0);
        @(negedge clk);
        rst = 1'b0;
        w_stall = 0;

        // recovery burst after reset
        exp_aw_q.push_back({32'h0000_8000, 8'd0});
        exp_w_q.push_back({1'b1, 4'h5, 32'h1234_5678});
        send(32'h8000, 32'h1234_5678, 4'h5, acc, r0);
        flush_pulse();
        wait_idle(200);

        check("aw_queue_drained", exp_aw_q.size(), 0);
        check("w_queue_drained", exp_w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
